instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loads a program into external memory, then streams
// fetched bytes through a 2-entry buffer with branch redirect and halt.
module instruction_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_load,
   input  logic       load_valid,
   input  logic [7:0] load_data,
   input  logic       load_done,
   input  logic       run,
   input  logic       halt,
   input  logic       branch_valid,
   input  logic [7:0] branch_target,
   output logic       instr_valid,
   input  logic       instr_ready,
   output logic [7:0] instr,
   output logic [7:0] instr_pc,
   output logic [7:0] mem_add,
   output logic       mem_rw,
   output logic [7:0] mem_ip,
   input  logic [7:0] mem_op,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_BAD  = 2'b11
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] load_ptr_q, load_ptr_d;
   logic [7:0] fifo_pc    [2];
   logic [7:0] fifo_instr [2];
   logic       rd_ptr_q, wr_ptr_q;
   logic [1:0] count_q;
   logic       pend_q;
   logic [7:0] pend_pc_q;
   logic       pop, push, issue, flush;
   logic [1:0] occ_after_pop;

   // instr_valid/instr_ready: the head transfers on a rising edge where both
   // are high; while valid is high and ready is low the head is held unchanged.
   assign instr_valid   = (count_q != 2'd0);
   assign pop           = instr_valid & instr_ready;
   assign push          = pend_q & ~flush;
   assign occ_after_pop = count_q - {1'b0, pop};
   assign instr         = instr_valid ? fifo_instr[rd_ptr_q] : 8'h00;
   assign instr_pc      = instr_valid ? fifo_pc[rd_ptr_q] : 8'h00;
   assign state         = state_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      load_ptr_d = load_ptr_q;
      mem_rw     = 1'b1;
      mem_add    = pc_q;
      mem_ip     = 8'h00;
      issue      = 1'b0;
      flush      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_load) begin
               state_d    = S_LOAD;
               load_ptr_d = 8'h00;
            end else if (run) begin
               state_d = S_RUN;
               pc_d    = RESET_PC;
               flush   = 1'b1;
            end
         end
         S_LOAD: begin
            mem_add = load_ptr_q;
            if (load_valid) begin
               mem_rw     = 1'b0;
               mem_ip     = load_data;
               load_ptr_d = load_ptr_q + 8'd1;
            end
            if (load_done) state_d = S_IDLE;
         end
         S_RUN: begin
            if (halt) begin
               state_d = S_IDLE;
               flush   = 1'b1;
            end else if (branch_valid) begin
               pc_d  = branch_target;
               flush = 1'b1;
            end else if ((occ_after_pop + {1'b0, pend_q}) < 2'd2) begin
               // Reserve a buffer slot for every read before it is issued.
               issue = 1'b1;
               pc_d  = pc_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         load_ptr_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         load_ptr_q <= load_ptr_d;
      end
   end

   // A read issued in one cycle returns on mem_op during the next one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         pend_q    <= 1'b0;
         pend_pc_q <= 8'h00;
         for (int i = 0; i < 2; i++) begin
            fifo_pc[i]    <= 8'h00;
            fifo_instr[i] <= 8'h00;
         end
      end else if (flush) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         pend_q   <= 1'b0;
      end else begin
         if (push) begin
            fifo_pc[wr_ptr_q]    <= pend_pc_q;
            fifo_instr[wr_ptr_q] <= mem_op;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
         pend_q  <= issue;
         if (issue) pend_pc_q <= pc_q;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table-driven load vectors, directed fetch
// sequences, and randomized load/run traffic scored against a memory model.
module tb_instruction_fetch_unit;

   localparam logic [7:0] RESET_PC = 8'h00;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_load, load_valid, load_done, run, halt, branch_valid;
   logic [7:0] load_data, branch_target;
   logic       instr_valid, instr_ready;
   logic [7:0] instr, instr_pc, mem_add, mem_ip, mem_op;
   logic       mem_rw;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem     [256];
   logic [7:0]  ref_mem [256];
   bit          mem_init_done;
   logic [15:0] exp_q [$];

   typedef struct {
      logic       sl, rn, lv, ld, bv;
      logic [7:0] data;
      logic [1:0] st;
      logic       rw;
      logic       chk;
      logic [7:0] add, ip;
   } load_vec_t;
   load_vec_t vecs [7];

   instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .start_load(start_load), .load_valid(load_valid),
      .load_data(load_data), .load_done(load_done), .run(run), .halt(halt),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .mem_add(mem_add), .mem_rw(mem_rw), .mem_ip(mem_ip),
      .mem_op(mem_op), .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   // Synchronous memory: write on the edge, read data available the cycle after.
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
         mem_init_done <= 1'b1;
      end else begin
         if (!mem_rw) mem[mem_add] <= mem_ip;
         mem_op <= mem[mem_add];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start_load = 1'b0; load_valid = 1'b0; load_done = 1'b0; run = 1'b0;
      halt = 1'b0; branch_valid = 1'b0; load_data = 8'h00;
   endtask

   task automatic refill(input logic [7:0] from);
      logic [7:0] a;
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         a = 8'(int'(from) + i);
         exp_q.push_back({a, ref_mem[a]});
      end
   endtask

   task automatic compare_mem(input string name);
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      check(name, 32'(bad), 32'd0);
   endtask

   task automatic expect_head(input string name, input logic [7:0] p);
      check(name, 32'({instr_valid, instr_pc, instr}), 32'({1'b1, p, ref_mem[p]}));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int          wcnt, n, deliveries;
      logic [7:0]  ptr;
      bit          prev_hold;
      logic [15:0] prev_word;

      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, 2'b00, 1'b1, 1'b1, RESET_PC, 8'h00};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA1, 2'b01, 1'b0, 1'b1, 8'h00, 8'hA1};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 2'b01, 1'b1, 1'b0, 8'h00, 8'h00};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 2'b01, 1'b0, 1'b1, 8'h01, 8'hB2};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 2'b01, 1'b0, 1'b1, 8'h02, 8'hC3};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, RESET_PC, 8'h00};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 2'b00, 1'b1, 1'b1, RESET_PC, 8'h00};

      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      reset = 1'b0;
      idle_inputs();
      instr_ready = 1'b0;
      branch_target = 8'h99;

      // Clock and reset
      #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", 32'({instr_pc, instr}), 32'd0);
      check("rst_mem_if", 32'({mem_rw, mem_add, mem_ip}), 32'({1'b1, RESET_PC, 8'h00}));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 check("rst_release_state", 32'(state), 32'd0);

      // Load vectors
      wcnt = 0;
      foreach (vecs[v]) begin
         @(negedge clk);
         start_load = vecs[v].sl; run = vecs[v].rn; load_valid = vecs[v].lv;
         load_done = vecs[v].ld; branch_valid = vecs[v].bv; load_data = vecs[v].data;
         #1;
         check("vec_state", 32'(state), 32'(vecs[v].st));
         check("vec_rw", 32'(mem_rw), 32'(vecs[v].rw));
         if (vecs[v].chk) check("vec_add_ip", 32'({mem_add, mem_ip}), 32'({vecs[v].add, vecs[v].ip}));
         if (!mem_rw) wcnt++;
      end
      @(negedge clk);
      idle_inputs();
      #1;
      check("idle_branch_ignored", 32'(mem_add), 32'(RESET_PC));
      check("load_write_cycles", 32'(wcnt), 32'd3);
      ref_mem[0] = 8'hA1; ref_mem[1] = 8'hB2; ref_mem[2] = 8'hC3;
      compare_mem("load_mem");

      // Fetch with instr_ready held high
      @(negedge clk); run = 1'b1; instr_ready = 1'b1; #1;
      check("fetch_idle", 32'(state), 32'd0);
      @(negedge clk); run = 1'b0; #1;
      check("run_enter", 32'(state), 32'd2);
      check("run_lat0", 32'(instr_valid), 32'd0);
      check("run_first_addr", 32'(mem_add), 32'(RESET_PC));
      @(negedge clk); #1 check("run_lat1", 32'(instr_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1 expect_head("fetch_seq", 8'(k));
      end
      @(negedge clk); halt = 1'b1; branch_valid = 1'b1; branch_target = 8'h80; #1;
      @(negedge clk); halt = 1'b0; branch_valid = 1'b0; #1;
      check("halt_prio_state", 32'(state), 32'd0);
      check("halt_flush", 32'(instr_valid), 32'd0);
      check("halt_pc", 32'(mem_add), 32'h05);

      // Backpressure
      @(negedge clk); run = 1'b1; instr_ready = 1'b0; #1;
      @(negedge clk); run = 1'b0; #1;
      @(negedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         expect_head("bp_hold", 8'h00);
         check("bp_no_issue", 32'(mem_add), 32'h02);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); instr_ready = 1'b1; #1 expect_head("bp_release", 8'(k));
      end

      // Branch with a read in flight
      @(negedge clk); branch_valid = 1'b1; branch_target = 8'h40; #1;
      @(negedge clk); branch_valid = 1'b0; #1;
      check("br_flush", 32'(instr_valid), 32'd0);
      check("br_issue_addr", 32'(mem_add), 32'h40);
      @(negedge clk); #1 check("br_lat", 32'(instr_valid), 32'd0);
      @(negedge clk); #1 expect_head("br_head", 8'h40);
      @(negedge clk); #1 expect_head("br_next", 8'h41);

      // Wrap
      @(negedge clk); branch_valid = 1'b1; branch_target = 8'hFF; #1;
      @(negedge clk); branch_valid = 1'b0; #1 check("wrap_issue", 32'(mem_add), 32'hFF);
      @(negedge clk); #1 check("wrap_pc", 32'(mem_add), 32'h00);
      @(negedge clk); #1 expect_head("wrap_ff", 8'hFF);
      @(negedge clk); #1 expect_head("wrap_00", 8'h00);

      // Asynchronous reset mid-RUN with the buffer full
      @(negedge clk); instr_ready = 1'b0; #1;
      @(negedge clk); #1;
      @(negedge clk); #1 check("pre_reset_valid", 32'(instr_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_valid", 32'(instr_valid), 32'd0);
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_instr", 32'({instr_pc, instr}), 32'd0);
      check("async_rst_mem_if", 32'({mem_rw, mem_add, mem_ip}), 32'({1'b1, RESET_PC, 8'h00}));
      @(negedge clk); reset = 1'b1; #1;
      check("post_rst_state", 32'(state), 32'd0);
      compare_mem("mem_after_directed");

      // Randomized load / run traffic
      for (int iter = 0; iter < 4; iter++) begin
         @(negedge clk); start_load = 1'b1; #1;
         check("rnd_pre_load", 32'(state), 32'd0);
         ptr = 8'h00;
         n = $urandom_range(3, 30);
         for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start_load = 1'b0;
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = 8'($urandom);
            load_done  = (c == n - 1);
            #1;
            check("rnd_load_state", 32'(state), 32'd1);
            check("rnd_load_rw", 32'(mem_rw), 32'(!load_valid));
            if (load_valid) begin
               check("rnd_load_wr", 32'({mem_add, mem_ip}), 32'({ptr, load_data}));
               ref_mem[ptr] = load_data;
               ptr = ptr + 8'd1;
            end
         end
         @(negedge clk); idle_inputs(); #1;
         check("rnd_load_exit", 32'({state, mem_rw}), 32'({2'b00, 1'b1}));
         compare_mem("rnd_load_mem");

         @(negedge clk); run = 1'b1; instr_ready = 1'b0; #1;
         refill(RESET_PC);
         prev_hold = 1'b0;
         prev_word = 16'h0000;
         deliveries = 0;
         for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            run = 1'b0;
            instr_ready   = 1'($urandom_range(0, 1));
            branch_valid  = ($urandom_range(0, 15) == 0);
            branch_target = 8'($urandom);
            #1;
            if (prev_hold)
               check("rnd_hold_stable", 32'({instr_valid, instr_pc, instr}), 32'({1'b1, prev_word}));
            check("rnd_run_read_only", 32'(mem_rw), 32'd1);
            if (instr_valid && instr_ready) begin
               check("rnd_deliver", 32'({instr_pc, instr}), 32'(exp_q.pop_front()));
               deliveries++;
            end
            prev_hold = instr_valid && !instr_ready && !branch_valid;
            prev_word = {instr_pc, instr};
            if (branch_valid) refill(branch_target);
         end
         @(negedge clk); branch_valid = 1'b0; halt = 1'b1; #1;
         @(negedge clk); halt = 1'b0; #1;
         check("rnd_halt", 32'({state, instr_valid}), 32'({2'b00, 1'b0}));
         check("rnd_liveness", 32'(deliveries >= 20), 32'd1);
      end
      compare_mem("final_mem");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
